// File: rtl/rca_bist_pkg.sv
// Shared types and sizing helpers for the ripple-carry adder BIST controller.
package rca_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam int unsigned DEF_WIDTH = 4;

  function automatic int unsigned vec_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned width);
    return 2 * width + 2;
  endfunction

  localparam int unsigned VEC_W   = vec_w(DEF_WIDTH);
  localparam int unsigned CNT_W   = cnt_w(DEF_WIDTH);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

endpackage

// File: rtl/rca_bist_controller_if.sv
// Adder-facing operand/result bus plus run control and status of the BIST controller.
interface rca_bist_controller_if #(parameter int WIDTH = 4) ();
  logic                 start;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cin;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 error;
  logic [2*WIDTH+1:0]   err_cnt;
  logic                 fail_valid;
  logic [2*WIDTH:0]     fail_vec;

  modport master (
    input  start, sum, cout,
    output a, b, cin, busy, done, pass, error, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, sum, cout,
    input  a, b, cin, busy, done, pass, error, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/rca_golden_check.sv
// Combinational golden model: flags when the adder's {cout, sum} differs from a+b+cin.
module rca_golden_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             mismatch
);
  logic [WIDTH:0] expected;

  assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign mismatch = (expected != {cout, sum});
endmodule

// File: rtl/rca_bist_controller.sv
// Exhaustive {cin, b, a} sweep of an external adder with pass/fail, error count and first-fail capture.
// Optional RCA_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module rca_bist_controller
  import rca_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rca_bist_controller_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start, results cleared
  // APPLY | vector driven, settle counter running
  // CHECK | adder output compared against golden sum
  // DONE  | verdict held until next start
  localparam int VW = vec_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE - 1);

  bist_state_t    state, state_nxt;
  logic [VW-1:0]  vec;
  logic [SW-1:0]  settle_cnt;
  logic [CW-1:0]  err_cnt;
  logic           fail_valid;
  logic [VW-1:0]  fail_vec;
  logic           error_q;
  logic           mismatch;
  logic           last_vec;

  assign last_vec = &vec;

  rca_golden_check #(.WIDTH(WIDTH)) u_check (
    .a        (vec[WIDTH-1:0]),
    .b        (vec[2*WIDTH-1:WIDTH]),
    .cin      (vec[2*WIDTH]),
    .sum      (bus.sum),
    .cout     (bus.cout),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = APPLY;
      APPLY: if (settle_cnt == '0) state_nxt = CHECK;
      CHECK: begin
        if (last_vec) state_nxt = DONE;
        else          state_nxt = APPLY;
`ifdef RCA_BIST_STOP_ON_FAIL_EN
        if (mismatch) state_nxt = DONE;
`endif
      end
      DONE:  if (bus.start) state_nxt = APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          vec        <= '0;
          err_cnt    <= '0;
          fail_valid <= 1'b0;
          fail_vec   <= '0;
          settle_cnt <= SETTLE_RELOAD;
        end
        APPLY: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
        end
        CHECK: begin
          if (mismatch) begin
            error_q <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec;
            end
          end
          // vector outputs only move on the edge that returns to APPLY
          if (state_nxt == APPLY) begin
            vec        <= vec + VW'(1);
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        DONE: begin
          if (bus.start) begin
            vec        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a          = vec[WIDTH-1:0];
  assign bus.b          = vec[2*WIDTH-1:WIDTH];
  assign bus.cin        = vec[2*WIDTH];
  assign bus.busy       = (state == APPLY) || (state == CHECK);
  assign bus.done       = (state == DONE);
  assign bus.pass       = (state == DONE) && (err_cnt == '0);
  assign bus.error      = error_q;
  assign bus.err_cnt    = err_cnt;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;
endmodule

// File: tb/tb_rca_bist_controller.sv
// Scoreboard bench for rca_bist_controller: faulty-adder stimulus, arithmetic reference model, decoupled monitor.
module tb_rca_bist_controller;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;
  localparam int VW     = 2 * WIDTH + 1;
  localparam int NV     = 1 << VW;
  localparam int CW     = 2 * WIDTH + 2;
  localparam int CMAX   = (1 << CW) - 1;

  // fault kinds: 0 none, 1 sum bit stuck 0, 2 sum bit stuck 1, 3 cout stuck 0, 4 cout stuck 1
  typedef struct {
    int unsigned latency;
    int unsigned err_cnt;
    int unsigned pass;
    int unsigned fail_valid;
    int unsigned fail_vec;
    int unsigned pulses;
    int unsigned fin_vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   fault_kind;
  int   fault_bit;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_bist_controller_if #(.WIDTH(WIDTH)) bus ();

  rca_bist_controller #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [WIDTH:0] faulty_adder(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                                  input logic cv, input int kind, input int bitn);
    logic [WIDTH:0] o;
    o = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
    case (kind)
      1: o[bitn] = 1'b0;
      2: o[bitn] = 1'b1;
      3: o[WIDTH] = 1'b0;
      4: o[WIDTH] = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  assign {bus.cout, bus.sum} = faulty_adder(bus.a, bus.b, bus.cin, fault_kind, fault_bit);

  // Walk every vector in sweep order, comparing the faulty adder against plain a+b+cin.
  function automatic exp_t model(input int kind, input int bitn);
    exp_t e;
    int unsigned n = 0;
    int unsigned first = 0;
    bit any = 0;
    for (int v = 0; v < NV; v++) begin
      int unsigned av, bv, cv, truth;
      logic [WIDTH:0] got;
      av = v % (1 << WIDTH);
      bv = (v / (1 << WIDTH)) % (1 << WIDTH);
      cv = v / (1 << (2 * WIDTH));
      truth = av + bv + cv;
      got = faulty_adder(WIDTH'(av), WIDTH'(bv), cv[0], kind, bitn);
      if (32'(got) != truth) begin
        if (!any) first = v;
        any = 1;
        n++;
`ifdef RCA_BIST_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    e.pulses     = n;
    e.err_cnt    = (n > CMAX) ? CMAX : n;
    e.pass       = (n == 0) ? 1 : 0;
    e.fail_valid = any ? 1 : 0;
    e.fail_vec   = any ? first : 0;
    e.latency    = NV * (SETTLE + 1);
    e.fin_vec    = NV - 1;
`ifdef RCA_BIST_STOP_ON_FAIL_EN
    if (any) begin
      e.latency = (first + 1) * (SETTLE + 1);
      e.fin_vec = first;
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned cur_vec();
    return 32'({bus.cin, bus.b, bus.a});
  endfunction

  // Monitor: pops one expectation per rising done.
  initial begin
    bit prev_busy = 0;
    bit prev_done = 0;
    int unsigned t0 = 0;
    int unsigned pulses = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 0;
        prev_done = 0;
      end else begin
        if (bus.busy && !prev_busy) begin
          t0 = cyc;
          pulses = 0;
        end
        if (bus.error) pulses++;
        if (bus.done && !prev_done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got 1 want 0 (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            check("latency", cyc - t0, e.latency);
            check("err_cnt", 32'(bus.err_cnt), e.err_cnt);
            check("pass", 32'(bus.pass), e.pass);
            check("fail_valid", 32'(bus.fail_valid), e.fail_valid);
            check("fail_vec", 32'(bus.fail_vec), e.fail_vec);
            check("error_pulses", pulses, e.pulses);
            check("final_vec", cur_vec(), e.fin_vec);
          end
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < NV * (SETTLE + 1) + 50) begin
      @(negedge clk);
      if (bus.done) break;
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got 0 want 1 (t=%0t)", $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'(bus.a), 0);
    check({tag, "_b"}, 32'(bus.b), 0);
    check({tag, "_cin"}, 32'(bus.cin), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_pass"}, 32'(bus.pass), 0);
    check({tag, "_error"}, 32'(bus.error), 0);
    check({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
    check({tag, "_fail_valid"}, 32'(bus.fail_valid), 0);
    check({tag, "_fail_vec"}, 32'(bus.fail_vec), 0);
  endtask

  task automatic run(input int kind, input int bitn, input bit repulse);
    fault_kind = kind;
    fault_bit  = bitn;
    sb.push_back(model(kind, bitn));
    pulse_start();
    if (repulse) begin
      repeat ($urandom_range(5, 300)) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    bus.start  = 1'b0;
    fault_kind = 0;
    fault_bit  = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    run(0, 0, 0);
    run(1, 0, 0);
    run(3, 0, 0);

    // start while DONE after a failing run: done drops and results clear on that edge
    fault_kind = 0;
    sb.push_back(model(0, 0));
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("restart_done", 32'(bus.done), 0);
    check("restart_busy", 32'(bus.busy), 1);
    check("restart_err_cnt", 32'(bus.err_cnt), 0);
    check("restart_fail_valid", 32'(bus.fail_valid), 0);
    check("restart_vec", cur_vec(), 0);
    wait_done();

    run(0, 0, 1);

    // reset mid-run at vector 100
    fault_kind = 0;
    pulse_start();
    n = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (cur_vec() == 100) break;
      n++;
    end
    check("reached_vec100", cur_vec(), 100);
    #1 rst = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    run(0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      run(int'($urandom_range(0, 4)), int'($urandom_range(0, WIDTH - 1)), 0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
